// File: rtl/conv_layer_sched.sv
// conv_layer_sched: feeds 3x3 windows per kernel pass and tags pooled results.
// Optional drain watchdog enabled by defining CONV_SCHED_WATCHDOG_EN.
module conv_layer_sched #(
   parameter int NUM_KERNELS   = 4,
   parameter int WIN_COLS      = 26,
   parameter int WIN_ROWS      = 26,
   parameter int POOL_OUTS     = 169,
   parameter int DRAIN_TIMEOUT = 1024,
   localparam int KW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          err,
   input  logic [71:0]   win_data,
   input  logic          win_valid,
   output logic          win_ready,
   output logic [71:0]   dp_data,
   output logic          dp_valid,
   output logic [KW-1:0] dp_kernel,
   input  logic [15:0]   mp_data,
   input  logic          mp_valid,
   output logic [15:0]   res_data,
   output logic          res_valid,
   output logic [KW-1:0] res_kernel,
   output logic [7:0]    res_index
);

   localparam int NWIN = WIN_COLS * WIN_ROWS;
   localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;
   localparam int PW   = $clog2(POOL_OUTS + 1);
   localparam logic [WW-1:0] WIN_LAST  = WW'(NWIN - 1);
   localparam logic [PW-1:0] POOL_FULL = PW'(POOL_OUTS);
   localparam logic [KW-1:0] KER_LAST  = KW'(NUM_KERNELS - 1);

   typedef enum logic [2:0] {IDLE, FEED, DRAIN, NEXT, FIN} state_t;

   state_t        state;
   logic [WW-1:0] win_cnt;
   logic [PW-1:0] pool_cnt;
   logic [KW-1:0] kernel;
   logic          accept;
   logic          pool_take;

   assign accept    = win_valid && win_ready;
   assign pool_take = mp_valid && (state == FEED || state == DRAIN)
                      && (pool_cnt != POOL_FULL);

`ifdef CONV_SCHED_WATCHDOG_EN
   localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [TW-1:0] WD_LAST = TW'(DRAIN_TIMEOUT - 1);
   logic [TW-1:0] wd_cnt;
`else
   localparam int UNUSED_TIMEOUT = DRAIN_TIMEOUT;
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         win_cnt    <= '0;
         pool_cnt   <= '0;
         kernel     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         win_ready  <= 1'b0;
         dp_data    <= '0;
         dp_valid   <= 1'b0;
         dp_kernel  <= '0;
         res_data   <= '0;
         res_valid  <= 1'b0;
         res_kernel <= '0;
         res_index  <= '0;
`ifdef CONV_SCHED_WATCHDOG_EN
         err        <= 1'b0;
         wd_cnt     <= '0;
`endif
      end else begin
         done      <= 1'b0;
         dp_valid  <= accept;
         res_valid <= pool_take;
         if (accept) begin
            dp_data   <= win_data;
            dp_kernel <= kernel;
         end
         // index is the pool count before this result is counted
         if (pool_take) begin
            res_data   <= mp_data;
            res_kernel <= kernel;
            res_index  <= 8'(pool_cnt);
            pool_cnt   <= pool_cnt + 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  win_cnt   <= '0;
                  pool_cnt  <= '0;
                  kernel    <= '0;
                  busy      <= 1'b1;
                  win_ready <= 1'b1;
                  state     <= FEED;
`ifdef CONV_SCHED_WATCHDOG_EN
                  err       <= 1'b0;
`endif
               end
            end
            FEED: begin
               if (accept) begin
                  if (win_cnt == WIN_LAST) begin
                     win_ready <= 1'b0;
                     state     <= DRAIN;
`ifdef CONV_SCHED_WATCHDOG_EN
                     wd_cnt    <= '0;
`endif
                  end else begin
                     win_cnt <= win_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (pool_cnt == POOL_FULL) begin
                  if (kernel == KER_LAST) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     state <= NEXT;
                  end
               end
`ifdef CONV_SCHED_WATCHDOG_EN
               else if (pool_take) begin
                  wd_cnt <= '0;
               end else if (wd_cnt == WD_LAST) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end
            NEXT: begin
               kernel    <= kernel + 1'b1;
               win_cnt   <= '0;
               pool_cnt  <= '0;
               win_ready <= 1'b1;
               state     <= FEED;
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy      <= 1'b0;
               win_ready <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
